// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. A round-robin arbiter
// picks the owner, and a three-state FSM (IDLE, EXEC, DONE) runs one op per grant.
module alu_share_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [2:0] op0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] op1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [1:0] grant,
    output logic [1:0] ack,
    output logic [7:0] result,
    output logic       err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_ACC = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;
    localparam logic [2:0] OP_ADD = 3'd1;

    state_t     state_reg;
    logic       last_reg;
    logic       id_reg;
    logic       err_pend_reg;
    logic [3:0] alu_a_reg;
    logic [3:0] alu_b_reg;
    logic [2:0] alu_op_reg;
    logic [1:0] grant_reg;
    logic [1:0] ack_reg;
    logic [7:0] result_reg;
    logic       err_reg;
    logic       busy_reg;

    logic [3:0] req_a  [2];
    logic [3:0] req_b  [2];
    logic [2:0] req_op [2];

    assign req_a[0]  = a0;
    assign req_b[0]  = b0;
    assign req_op[0] = op0;
    assign req_a[1]  = a1;
    assign req_b[1]  = b1;
    assign req_op[1] = op1;

    // A lone requester wins outright; on a tie the one not served last wins.
    logic       winner;
    logic [1:0] winner_onehot;
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11)
            winner = ~last_reg;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
        assign winner_onehot[gi] = (winner == 1'(gi));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            id_reg       <= 1'b0;
            err_pend_reg <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            grant_reg    <= '0;
            ack_reg      <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= '0;
                    err_reg <= 1'b0;
                    if (|req) begin
                        id_reg       <= winner;
                        grant_reg    <= winner_onehot;
                        busy_reg     <= 1'b1;
                        err_pend_reg <= (req_op[winner] == OP_RSV);
                        alu_a_reg    <= req_a[winner];
                        // Accumulate reuses the adder with the low nibble of the last result.
                        if (req_op[winner] == OP_ACC) begin
                            alu_op_reg <= OP_ADD;
                            alu_b_reg  <= result_reg[3:0];
                        end else begin
                            alu_op_reg <= req_op[winner];
                            alu_b_reg  <= req_b[winner];
                        end
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_result;
                    alu_a_reg  <= '0;
                    alu_b_reg  <= '0;
                    alu_op_reg <= '0;
                    ack_reg    <= grant_reg;
                    err_reg    <= err_pend_reg;
                    state_reg  <= DONE;
                end
                DONE: begin
                    ack_reg   <= '0;
                    err_reg   <= 1'b0;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                    last_reg  <= id_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_a  = alu_a_reg;
    assign alu_b  = alu_b_reg;
    assign alu_op = alu_op_reg;
    assign grant  = grant_reg;
    assign ack    = ack_reg;
    assign result = result_reg;
    assign err    = err_reg;
    assign busy   = busy_reg;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU sits on the alu_* path, and a
// scoreboard queue holds the expected ack/result/err for each granted op.
module tb_alu_share_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = '0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] op0 = '0, op1 = '0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic [1:0] grant, ack;
    logic [7:0] result;
    logic       err, busy;

    typedef struct packed {
        logic [1:0] ack;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] m_result = '0;

    alu_share_ctrl dut (
        .clock(clock), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .grant(grant), .ack(ack), .result(result), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return {a, b};
            3'd1:    return {4'h0, a} + {4'h0, b};
            3'd2:    return {4'h0, a} - {4'h0, b};
            3'd3:    return {4'h0, a & b};
            3'd4:    return {4'h0, a | b};
            3'd5:    return {4'h0, a ^ b};
            3'd6:    return {4'h0, a} * {4'h0, b};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [7:0] res, input logic e);
        exp_t x;
        x.ack = 2'(1 << id);
        x.res = res;
        x.err = e;
        sb.push_back(x);
    endtask

    always @(negedge clock) begin
        if (!reset && ack != 2'b00) begin
            $display("txn: ack=%b result=%h err=%b", ack, result, err);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_id", 32'(ack), 32'(e.ack));
                check("result", 32'(result), 32'(e.res));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        m_result = '0;
    endtask

    // One complete op by a single requester, with cycle-exact checks in EXEC, DONE and IDLE.
    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input bit perturb);
        logic [7:0] exp_res;
        logic [3:0] exp_b;
        logic [2:0] exp_op;
        exp_b  = (op == 3'd6) ? m_result[3:0] : b;
        exp_op = (op == 3'd6) ? 3'd1 : op;
        exp_res = (op == 3'd7) ? 8'h00 : alu_f(exp_op, a, exp_b);
        m_result = exp_res;
        push(id, exp_res, op == 3'd7);
        @(negedge clock);
        if (id == 0) begin a0 = a; b0 = b; op0 = op; end
        else         begin a1 = a; b1 = b; op1 = op; end
        req = 2'(1 << id);
        @(posedge clock);
        #1;
        req = '0;
        if (perturb) begin
            a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b;
        end
        check("exec_grant", 32'(grant), 32'(1 << id));
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ack", 32'(ack), 32'd0);
        check("exec_alu_op", 32'(alu_op), 32'(exp_op));
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(exp_b));
        @(posedge clock);
        #1;
        check("done_ack", 32'(ack), 32'(1 << id));
        check("done_grant", 32'(grant), 32'(1 << id));
        @(posedge clock);
        #1;
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    endtask

    initial begin
        int got;
        int last_cyc;
        do_reset();

        // Plain add by requester 0.
        run_op(0, 4'h3, 4'h5, 3'd1, 1'b0);

        // Both held: service alternates starting with requester 0, one op every 3 cycles.
        do_reset();
        @(negedge clock);
        a0 = 4'h1; b0 = 4'h2; op0 = 3'd0;
        a1 = 4'hA; b1 = 4'hB; op1 = 3'd0;
        for (int i = 0; i < 4; i++) push(i % 2, (i % 2 == 0) ? 8'h12 : 8'hAB, 1'b0);
        m_result = 8'hAB;
        req = 2'b11;
        got = 0;
        last_cyc = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            @(posedge clock);
            #1;
            if (ack != 2'b00) begin
                if (got > 0) check("ack_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                got++;
                if (got == 4) req = '0;
            end
        end
        check("rr_ack_count", 32'(got), 32'd4);
        @(posedge clock);

        // Accumulate from a known result.
        run_op(0, 4'h2, 4'h2, 3'd1, 1'b0);
        run_op(1, 4'h3, 4'h0, 3'd6, 1'b0);
        run_op(1, 4'h3, 4'h0, 3'd6, 1'b0);

        // Reserved opcode.
        run_op(0, 4'h5, 4'h6, 3'd7, 1'b0);

        // Reset in EXEC aborts the op and returns the pointer to requester 0.
        run_op(0, 4'h4, 4'h4, 3'd1, 1'b0);
        @(negedge clock);
        a0 = 4'h1; b0 = 4'h1; op0 = 3'd1;
        req = 2'b01;
        @(posedge clock);
        #1;
        check("abort_busy_exec", 32'(busy), 32'd1);
        reset = 1'b1;
        req = '0;
        @(posedge clock);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m_result = '0;
        a0 = 4'h1; b0 = 4'h2; op0 = 3'd0;
        a1 = 4'h7; b1 = 4'h7; op1 = 3'd1;
        push(0, 8'h12, 1'b0);
        req = 2'b11;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(posedge clock);
            #1;
            if (ack != 2'b00) begin
                got = 1;
                req = '0;
            end
        end
        check("post_reset_ack_seen", 32'(got), 32'd1);
        @(posedge clock);
        m_result = 8'h12;

        // Operands changed and req dropped during EXEC: latched values still used.
        run_op(0, 4'h3, 4'h4, 3'd1, 1'b1);

        repeat (2) @(posedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
